// File: rtl/cpu_pkg.sv
// Shared definitions for the EX/WB slice: datapath sizes and the encodings
// of the ALU operation, B-path shift and B-operand select fields.
package cpu_pkg;

  localparam int CPU_DATA_W    = 16;
  localparam int CPU_REG_NUM_W = 3;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    BSEL_RM   = 2'b00,
    BSEL_IMM5 = 2'b01,
    BSEL_IMM8 = 2'b10,
    BSEL_RSVD = 2'b11
  } bsel_t;

endpackage

// File: rtl/ex_wb_stage_alu_shift.sv
// alu_shift: purely combinational B-path shifter, B-operand select, ALU and
// Z/N/V generation.
//   i_a      A operand (already forwarded and zero-forced)
//   i_rm     forwarded Rm value, shifted before use as B
//   i_imm5   sign-extended imm5 (B when i_bsel = BSEL_IMM5)
//   i_imm8   sign-extended imm8 (B when i_bsel = BSEL_IMM8)
//   i_shift  shift applied to Rm
//   i_bsel   B-operand source; BSEL_RSVD behaves as BSEL_RM
//   i_op     ALU operation
//   o_result result, modulo 2^DATA_W
//   o_z/o_n/o_v  zero, negative, signed overflow (ADD/SUB only)
module alu_shift
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_rm,
  input  logic [DATA_W-1:0] i_imm5,
  input  logic [DATA_W-1:0] i_imm8,
  input  shift_t            i_shift,
  input  bsel_t             i_bsel,
  input  alu_op_t           i_op,
  output logic [DATA_W-1:0] o_result,
  output logic              o_z,
  output logic              o_n,
  output logic              o_v
);

  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_b;
  logic              w_a_msb;
  logic              w_b_msb;
  logic              w_r_msb;

  always_comb begin
    w_shifted = i_rm;
    case (i_shift)
      SH_LSL1: w_shifted = {i_rm[DATA_W-2:0], 1'b0};
      SH_LSR1: w_shifted = {1'b0, i_rm[DATA_W-1:1]};
      SH_ASR1: w_shifted = {i_rm[DATA_W-1], i_rm[DATA_W-1:1]};
      default: w_shifted = i_rm;
    endcase
  end

  always_comb begin
    w_b = w_shifted;
    case (i_bsel)
      BSEL_IMM5: w_b = i_imm5;
      BSEL_IMM8: w_b = i_imm8;
      default:   w_b = w_shifted;
    endcase
  end

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD: o_result = i_a + w_b;
      ALU_SUB: o_result = i_a - w_b;
      ALU_AND: o_result = i_a & w_b;
      ALU_MVN: o_result = ~w_b;
      default: o_result = '0;
    endcase
  end

  assign w_a_msb = i_a[DATA_W-1];
  assign w_b_msb = w_b[DATA_W-1];
  assign w_r_msb = o_result[DATA_W-1];

  // Signed overflow: ADD overflows when like-signed operands give a result of
  // the other sign; SUB when unlike-signed operands give a result whose sign
  // differs from A.
  always_comb begin
    o_v = 1'b0;
    case (i_op)
      ALU_ADD: o_v = (w_a_msb == w_b_msb) && (w_r_msb != w_a_msb);
      ALU_SUB: o_v = (w_a_msb != w_b_msb) && (w_r_msb != w_a_msb);
      default: o_v = 1'b0;
    endcase
  end

  assign o_z = (o_result == '0);
  assign o_n = w_r_msb;

endmodule

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: consumes the ID/EX bundle, applies EX/WB-to-EX forwarding,
// runs the shifter/ALU and captures the result in the EX/WB stage register,
// which drives the register-file write port, the Z/N/V flags and a counter
// of retired instructions. Adds stall, flush and valid handling.
//   clk, reset (async, active-low)
//   valid_e, rn_e, rm_e, imm5_e, imm8_e, rn/rm/rd_num_e, alu_op_e, shift_e,
//   write_e, status_en_e, asel_e, bsel_e : EX bundle
//   stall (hold stage + flags), flush (kill instruction entering WB)
//   wb_en, wb_num, wb_data, wb_valid : write port / WB slot state
//   z_flag, n_flag, v_flag, retire_count
module ex_wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W     = CPU_DATA_W,
  parameter int REG_NUM_W  = CPU_REG_NUM_W,
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_e,
  input  logic [DATA_W-1:0]    rn_e,
  input  logic [DATA_W-1:0]    rm_e,
  input  logic [DATA_W-1:0]    imm5_e,
  input  logic [DATA_W-1:0]    imm8_e,
  input  logic [REG_NUM_W-1:0] rn_num_e,
  input  logic [REG_NUM_W-1:0] rm_num_e,
  input  logic [REG_NUM_W-1:0] rd_num_e,
  input  logic [1:0]           alu_op_e,
  input  logic [1:0]           shift_e,
  input  logic                 write_e,
  input  logic                 status_en_e,
  input  logic                 asel_e,
  input  logic [1:0]           bsel_e,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 wb_en,
  output logic [REG_NUM_W-1:0] wb_num,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 wb_valid,
  output logic                 z_flag,
  output logic                 n_flag,
  output logic                 v_flag,
  output logic [15:0]          retire_count
);

  logic                 r_wb_valid;
  logic                 r_wb_write;
  logic [REG_NUM_W-1:0] r_wb_num;
  logic [DATA_W-1:0]    r_wb_data;
  logic                 r_z;
  logic                 r_n;
  logic                 r_v;
  logic [15:0]          r_retire;

  logic                 w_wb_en;
  logic                 w_fwd_rn;
  logic                 w_fwd_rm;
  logic [DATA_W-1:0]    w_a_raw;
  logic [DATA_W-1:0]    w_rm_raw;
  logic [DATA_W-1:0]    w_a;
  logic [DATA_W-1:0]    w_result;
  logic                 w_z;
  logic                 w_n;
  logic                 w_v;

  assign w_wb_en = r_wb_valid && r_wb_write;

  // Single bypass level: the register file is write-through, so only the
  // instruction currently in WB can be newer than the decode-time read.
  assign w_fwd_rn = FORWARD_EN && w_wb_en && (r_wb_num == rn_num_e);
  assign w_fwd_rm = FORWARD_EN && w_wb_en && (r_wb_num == rm_num_e);

  assign w_a_raw  = w_fwd_rn ? r_wb_data : rn_e;
  assign w_rm_raw = w_fwd_rm ? r_wb_data : rm_e;
  assign w_a      = asel_e ? '0 : w_a_raw;

  alu_shift #(
    .DATA_W (DATA_W)
  ) u_alu_shift (
    .i_a      (w_a),
    .i_rm     (w_rm_raw),
    .i_imm5   (imm5_e),
    .i_imm8   (imm8_e),
    .i_shift  (shift_t'(shift_e)),
    .i_bsel   (bsel_t'(bsel_e)),
    .i_op     (alu_op_t'(alu_op_e)),
    .o_result (w_result),
    .o_z      (w_z),
    .o_n      (w_n),
    .o_v      (w_v)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_valid <= 1'b0;
      r_wb_write <= 1'b0;
      r_wb_num   <= '0;
      r_wb_data  <= '0;
      r_z        <= 1'b0;
      r_n        <= 1'b0;
      r_v        <= 1'b0;
      r_retire   <= '0;
    end else begin
      // A valid WB slot retires when it advances or is flushed out.
      if (r_wb_valid && (flush || !stall))
        r_retire <= r_retire + 16'd1;

      if (flush) begin
        r_wb_valid <= 1'b0;
      end else if (!stall) begin
        r_wb_valid <= valid_e;
        r_wb_write <= write_e;
        r_wb_num   <= rd_num_e;
        r_wb_data  <= w_result;
        if (valid_e && status_en_e) begin
          r_z <= w_z;
          r_n <= w_n;
          r_v <= w_v;
        end
      end
    end
  end

  assign wb_en        = w_wb_en;
  assign wb_num       = r_wb_num;
  assign wb_data      = r_wb_data;
  assign wb_valid     = r_wb_valid;
  assign z_flag       = r_z;
  assign n_flag       = r_n;
  assign v_flag       = r_v;
  assign retire_count = r_retire;

endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;

  logic        clk;
  logic        reset;
  logic        valid_e;
  logic [15:0] rn_e, rm_e, imm5_e, imm8_e;
  logic [2:0]  rn_num_e, rm_num_e, rd_num_e;
  logic [1:0]  alu_op_e, shift_e, bsel_e;
  logic        write_e, status_en_e, asel_e;
  logic        stall, flush;
  logic        wb_en;
  logic [2:0]  wb_num;
  logic [15:0] wb_data;
  logic        wb_valid;
  logic        z_flag, n_flag, v_flag;
  logic [15:0] retire_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Small reference model of the valid bit and retirement counter.
  logic        m_valid = 1'b0;
  logic [15:0] exp_ret = '0;

  ex_wb_stage #(
    .DATA_W     (16),
    .REG_NUM_W  (3),
    .FORWARD_EN (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_e      (valid_e),
    .rn_e         (rn_e),
    .rm_e         (rm_e),
    .imm5_e       (imm5_e),
    .imm8_e       (imm8_e),
    .rn_num_e     (rn_num_e),
    .rm_num_e     (rm_num_e),
    .rd_num_e     (rd_num_e),
    .alu_op_e     (alu_op_e),
    .shift_e      (shift_e),
    .write_e      (write_e),
    .status_en_e  (status_en_e),
    .asel_e       (asel_e),
    .bsel_e       (bsel_e),
    .stall        (stall),
    .flush        (flush),
    .wb_en        (wb_en),
    .wb_num       (wb_num),
    .wb_data      (wb_data),
    .wb_valid     (wb_valid),
    .z_flag       (z_flag),
    .n_flag       (n_flag),
    .v_flag       (v_flag),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [1:0]  sh;
    logic [1:0]  bsel;
    logic        asel;
    logic        wr;
    logic        sen;
    logic [15:0] rn;
    logic [15:0] rm;
    logic [15:0] imm5;
    logic [15:0] imm8;
    logic [15:0] exp_data;
    logic        exp_en;
    logic [2:0]  exp_znv;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    valid_e = 1'b0; rn_e = '0; rm_e = '0; imm5_e = '0; imm8_e = '0;
    rn_num_e = 3'd1; rm_num_e = 3'd2; rd_num_e = 3'd7;
    alu_op_e = 2'b00; shift_e = 2'b00; bsel_e = 2'b00;
    write_e = 1'b0; status_en_e = 1'b0; asel_e = 1'b0;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] sh, input logic [1:0] bs,
                       input logic as, input logic wr, input logic sen,
                       input logic [15:0] rn, input logic [15:0] rm,
                       input logic [15:0] i5, input logic [15:0] i8);
    valid_e = 1'b1; alu_op_e = op; shift_e = sh; bsel_e = bs; asel_e = as;
    write_e = wr; status_en_e = sen; rn_e = rn; rm_e = rm; imm5_e = i5; imm8_e = i8;
  endtask

  // One clock: update the model from the inputs in effect, then sample 1 ns
  // after the rising edge.
  task automatic step();
    if (m_valid && (flush || !stall)) exp_ret = exp_ret + 16'd1;
    if (flush) m_valid = 1'b0;
    else if (!stall) m_valid = valid_e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{"add",      2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 16'h0005, 16'h0007, 16'h0000, 16'h0000, 16'h000C, 1'b1, 3'b000};
    tbl[1]  = '{"sub_neg",  2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 16'hFFFE, 1'b1, 3'b010};
    tbl[2]  = '{"and",      2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 16'hF0F0, 16'h3C3C, 16'h0000, 16'h0000, 16'h3030, 1'b1, 3'b000};
    tbl[3]  = '{"mvn",      2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h00FF, 16'h0000, 16'h0000, 16'hFF00, 1'b1, 3'b010};
    tbl[4]  = '{"asr1",     2'b00, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h8000, 16'h0000, 16'h0000, 16'hC000, 1'b1, 3'b010};
    tbl[5]  = '{"add_ovf",  2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h8000, 1'b1, 3'b011};
    tbl[6]  = '{"lsl1",     2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h8001, 16'h0000, 16'h0000, 16'h0002, 1'b1, 3'b000};
    tbl[7]  = '{"lsr1",     2'b00, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h8001, 16'h0000, 16'h0000, 16'h4000, 1'b1, 3'b000};
    tbl[8]  = '{"imm5",     2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b1, 16'h000A, 16'h1111, 16'hFFF0, 16'h0000, 16'hFFFA, 1'b1, 3'b010};
    tbl[9]  = '{"imm8_mov", 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 16'h5555, 16'h1111, 16'h0000, 16'h007F, 16'h007F, 1'b1, 3'b000};
    tbl[10] = '{"bsel11",   2'b00, 2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h0003, 1'b1, 3'b000};
    tbl[11] = '{"sub_ovf",  2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 3'b001};
    tbl[12] = '{"cmp",      2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'b100};

    idle();
    reset = 1'b1;
    #2 reset = 1'b0;
    #2;
    chk("reset_wb_en",   {31'd0, wb_en}, 32'd0);
    chk("reset_wb_data", {16'd0, wb_data}, 32'd0);
    chk("reset_valid",   {31'd0, wb_valid}, 32'd0);
    chk("reset_flags",   {29'd0, z_flag, n_flag, v_flag}, 32'd0);
    chk("reset_retire",  {16'd0, retire_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table: independent instructions (rd 7, sources 1/2, so no bypass).
    for (int i = 0; i < 13; i++) begin
      rn_num_e = 3'd1; rm_num_e = 3'd2; rd_num_e = 3'd7;
      drive(tbl[i].op, tbl[i].sh, tbl[i].bsel, tbl[i].asel, tbl[i].wr, tbl[i].sen,
            tbl[i].rn, tbl[i].rm, tbl[i].imm5, tbl[i].imm8);
      step();
      chk({tbl[i].name, "_data"},  {16'd0, wb_data}, {16'd0, tbl[i].exp_data});
      chk({tbl[i].name, "_en"},    {31'd0, wb_en}, {31'd0, tbl[i].exp_en});
      chk({tbl[i].name, "_valid"}, {31'd0, wb_valid}, 32'd1);
      chk({tbl[i].name, "_znv"},   {29'd0, z_flag, n_flag, v_flag}, {29'd0, tbl[i].exp_znv});
    end
    chk("table_retire", {16'd0, retire_count}, {16'd0, exp_ret});
    chk("table_retire_const", {16'd0, retire_count}, 32'd12);

    // Back-to-back dependency via the bypass.
    rn_num_e = 3'd2; rm_num_e = 3'd3; rd_num_e = 3'd1;
    drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 16'd5, 16'd7, 16'd0, 16'd0);
    step();
    chk("dep1_data", {16'd0, wb_data}, 32'd12);
    chk("dep1_num",  {29'd0, wb_num}, 32'd1);
    rn_num_e = 3'd1; rm_num_e = 3'd1; rd_num_e = 3'd4;
    drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0);
    step();
    chk("dep2_data", {16'd0, wb_data}, 32'd24);
    chk("dep2_num",  {29'd0, wb_num}, 32'd4);
    chk("dep_retire", {16'd0, retire_count}, {16'd0, exp_ret});

    // Stall twice, then stall+flush, then a bubble with status enabled.
    rn_num_e = 3'd1; rm_num_e = 3'd2; rd_num_e = 3'd5;
    drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1, 16'd0, 16'd0);
    step();
    chk("pre_stall_data", {16'd0, wb_data}, 32'd2);
    drive(2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0);
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall_data",   {16'd0, wb_data}, 32'd2);
      chk("stall_flags",  {29'd0, z_flag, n_flag, v_flag}, 32'd0);
      chk("stall_valid",  {31'd0, wb_valid}, 32'd1);
      chk("stall_retire", {16'd0, retire_count}, {16'd0, exp_ret});
    end
    flush = 1'b1;
    step();
    chk("flush_valid",  {31'd0, wb_valid}, 32'd0);
    chk("flush_en",     {31'd0, wb_en}, 32'd0);
    chk("flush_flags",  {29'd0, z_flag, n_flag, v_flag}, 32'd0);
    chk("flush_retire", {16'd0, retire_count}, {16'd0, exp_ret});
    stall = 1'b0; flush = 1'b0;
    valid_e = 1'b0;
    step();
    chk("bubble_flags", {29'd0, z_flag, n_flag, v_flag}, 32'd0);
    chk("bubble_valid", {31'd0, wb_valid}, 32'd0);
    chk("bubble_retire", {16'd0, retire_count}, {16'd0, exp_ret});

    // Asynchronous reset in the middle of a cycle with a live WB slot.
    rd_num_e = 3'd6;
    drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 16'h7FFF, 16'h0001, 16'd0, 16'd0);
    step();
    chk("pre_rst_en", {31'd0, wb_en}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_en",     {31'd0, wb_en}, 32'd0);
    chk("midrst_data",   {16'd0, wb_data}, 32'd0);
    chk("midrst_flags",  {29'd0, z_flag, n_flag, v_flag}, 32'd0);
    chk("midrst_retire", {16'd0, retire_count}, 32'd0);
    m_valid = 1'b0;
    exp_ret = '0;
    idle();
    @(negedge clk);
    reset = 1'b1;

    // Counter wrap: first edge only loads the slot, so 65536 edges retire
    // 65535 instructions; one more wraps the counter.
    valid_e = 1'b1;
    for (int k = 0; k < 65536; k++) step();
    chk("wrap_ffff", {16'd0, retire_count}, 32'h0000FFFF);
    step();
    chk("wrap_zero", {16'd0, retire_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
